// File: rtl/shift_cmd_seq.sv
// Command sequencer for a 4-bit universal shift register stage.
// It runs each accepted job as a fixed sequence: load, N shifts, hold, then a done pulse.
module shift_cmd_seq #(
  parameter int WIDTH       = 4,
  parameter int CNT_W       = 3,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CNT_W-1:0] in_count,
  output logic [1:0]       S,
  output logic [WIDTH-1:0] D,
  output logic             OE,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [7:0]       hold_q, hold_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      data_q   <= '0;
      dir_q    <= 1'b0;
      count_q  <= '0;
      remain_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      dir_q    <= dir_d;
      count_q  <= count_d;
      remain_q <= remain_d;
      hold_q   <= hold_d;
    end
  end

  // The hold counter is cleared everywhere except HOLD, so it always starts a hold phase at zero.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    dir_d    = dir_q;
    count_d  = count_q;
    remain_d = remain_q;
    hold_d   = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = LOAD;
          data_d  = in_data;
          dir_d   = in_dir;
          count_d = in_count;
        end
      end
      LOAD: begin
        if (count_q == '0) begin
          state_d = HOLD;
        end else begin
          state_d  = SHIFT;
          remain_d = count_q;
        end
      end
      SHIFT: begin
        remain_d = remain_q - CNT_W'(1);
        if (remain_q == CNT_W'(1)) state_d = HOLD;
      end
      HOLD: begin
        hold_d = hold_q + 8'd1;
        if (hold_q == HOLD_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    S        = 2'b00;
    D        = data_q;
    OE       = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        OE       = 1'b1;
        busy     = 1'b0;
        in_ready = 1'b1;
      end
      LOAD:  S = 2'b11;
      SHIFT: S = dir_q ? 2'b10 : 2'b01;
      HOLD:  S = 2'b00;
      DONE:  done = 1'b1;
      default: begin
        OE   = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Bench for shift_cmd_seq: directed and random jobs checked against a cycle plan
// built from the job rules, plus a downstream register model for the final Q value.
module tb_shift_cmd_seq;

  localparam int HOLD_CYCLES = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_dir = 1'b0;
  logic [2:0] in_count = 3'd0;
  logic       in_ready;
  logic [1:0] S;
  logic [3:0] D;
  logic       OE, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] s;
    logic       done;
  } step_t;

  logic [3:0] downstreamQ;

  shift_cmd_seq #(.WIDTH(4), .CNT_W(3), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dir(in_dir), .in_count(in_count),
    .S(S), .D(D), .OE(OE), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // Downstream universal shift register, zero fill on shifts.
  always @(posedge CLK) begin
    case (S)
      2'b11:   downstreamQ <= D;
      2'b01:   downstreamQ <= {1'b0, downstreamQ[3:1]};
      2'b10:   downstreamQ <= {downstreamQ[2:0], 1'b0};
      default: downstreamQ <= downstreamQ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".S"}, 32'(S), 32'd0);
    checkOutput({tag, ".OE"}, 32'(OE), 32'd1);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".done"}, 32'(done), 32'd0);
    checkOutput({tag, ".ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [3:0] data, input logic dir, input logic [2:0] cnt,
                               input bit noise, input bit keepValid);
    step_t plan[$];
    logic [3:0] expQ;
    plan.push_back('{s: 2'b11, done: 1'b0});
    for (int i = 0; i < int'(cnt); i++) plan.push_back('{s: (dir ? 2'b10 : 2'b01), done: 1'b0});
    for (int i = 0; i < HOLD_CYCLES; i++) plan.push_back('{s: 2'b00, done: 1'b0});
    plan.push_back('{s: 2'b00, done: 1'b1});
    expQ = dir ? 4'(int'(data) << cnt) : 4'(int'(data) >> cnt);

    in_valid = 1'b1;
    in_data  = data;
    in_dir   = dir;
    in_count = cnt;
    @(posedge CLK);
    #1;
    if (noise) begin
      in_data  = 4'($urandom);
      in_dir   = 1'($urandom);
      in_count = 3'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    foreach (plan[i]) begin
      @(negedge CLK);
      checkOutput($sformatf("job%0d.S", i), 32'(S), 32'(plan[i].s));
      checkOutput($sformatf("job%0d.D", i), 32'(D), 32'(data));
      checkOutput($sformatf("job%0d.OE", i), 32'(OE), 32'd0);
      checkOutput($sformatf("job%0d.busy", i), 32'(busy), 32'd1);
      checkOutput($sformatf("job%0d.done", i), 32'(done), 32'(plan[i].done));
      checkOutput($sformatf("job%0d.ready", i), 32'(in_ready), 32'd0);
      if (noise) begin
        in_data  = 4'($urandom);
        in_dir   = 1'($urandom);
        in_count = 3'($urandom);
      end
    end
    in_valid = keepValid;
    @(negedge CLK);
    checkIdle("after");
    checkOutput("downstreamQ", 32'(downstreamQ), 32'(expQ));
  endtask

  initial begin
    #3;
    RST = 1'b1;
    #1;
    checkIdle("reset");
    checkOutput("reset.D", 32'(D), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    checkIdle("postReset");

    applyStimulus(4'b1010, 1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(4'b1010, 1'b0, 3'd1, 1'b0, 1'b0);
    applyStimulus(4'b1110, 1'b1, 3'd5, 1'b1, 1'b0);

    applyStimulus(4'b0110, 1'b1, 3'd2, 1'b0, 1'b1);
    applyStimulus(4'b1001, 1'b0, 3'd3, 1'b0, 1'b0);

    in_valid = 1'b1;
    in_data  = 4'b1011;
    in_dir   = 1'b0;
    in_count = 3'd7;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge CLK);
    checkOutput("abort.preS", 32'(S), 32'b01);
    RST = 1'b1;
    #1;
    checkIdle("abort");
    checkOutput("abort.D", 32'(D), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("abort.noDone", 32'(done), 32'd0);
      checkOutput("abort.busy", 32'(busy), 32'd0);
    end
    RST = 1'b0;
    applyStimulus(4'b0101, 1'b1, 3'd3, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      applyStimulus(4'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                    (n < 19) ? 1'($urandom) : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_cmd_seq.md
Name: shift_cmd_seq

Overview:
- Upstream command sequencer for the 4-bit universal shift register stage (inputs OE, S[1:0], D, CLK).
- Accepts one job per valid/ready handshake. A job is a parallel word, a shift direction and a shift count.
- Drives the register's mode select S, parallel data D and output enable OE through a fixed sequence: load, N shifts, hold, done.
- The register stage shares CLK with this block and samples S and D on the same rising edge that advances this block's FSM.

Parameters:
- WIDTH, 4, parallel data width; must match the downstream shift register.
- CNT_W, 3, width of the shift-count field; maximum count is 2^CNT_W-1.
- HOLD_CYCLES, 2, number of cycles S=00 (hold) is driven after the last shift; legal range 1..255.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  job request.
- in_ready  output  1  block can accept a job.
- in_data  input  WIDTH  word to parallel-load.
- in_dir  input  1  shift direction: 0 = right (S=01), 1 = left (S=10).
- in_count  input  CNT_W  number of shift cycles to issue.
- S  output  2  mode select to the shift register: 00 hold, 01 right, 10 left, 11 load.
- D  output  WIDTH  parallel data to the shift register.
- OE  output  1  output enable to the shift register; 1 = outputs disabled, 0 = enabled.
- busy  output  1  a job is in progress.
- done  output  1  one-cycle pulse at job completion.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values: state=IDLE, S=00, D=0, OE=1, busy=0, done=0, in_ready=1, internal counters=0.
- Reset asserted mid-job aborts the job immediately. No done pulse is produced and the job is not resumed.
- Output timing: all outputs are registered Moore outputs decoded from the current state.
- Handshake: a job is accepted on a rising edge where in_valid=1 and in_ready=1.
  - in_ready=1 only in IDLE.
  - in_data, in_dir and in_count are captured into internal registers at acceptance.
  - Input changes after acceptance have no effect on the running job.
- IDLE: S=00, OE=1, busy=0. On acceptance, go to LOAD.
- LOAD (1 cycle): S=11, D=captured word, OE=0, busy=1.
  - count==0: go to HOLD.
  - otherwise: go to SHIFT with remaining=count.
- SHIFT (exactly count cycles): S=01 if dir=0, S=10 if dir=1. D keeps the captured word, OE=0, busy=1.
  - remaining decrements every cycle.
  - Leave to HOLD on the cycle where remaining==1.
- HOLD (exactly HOLD_CYCLES cycles): S=00, OE=0, busy=1. Uses an 8-bit hold counter. Then go to DONE.
- DONE (1 cycle): done=1, S=00, OE=0, busy=1. Then go to IDLE, where OE returns to 1.
- Job length: from the acceptance edge to the first IDLE cycle is 1 + count + HOLD_CYCLES + 1 cycles.
- Back-to-back jobs: at least one IDLE cycle separates jobs. The next acceptance can occur on the first rising edge after entering IDLE.
- Counts: count >= WIDTH is legal. The sequencer issues exactly count shift commands regardless of WIDTH; fill bits are the downstream register's concern.
- Counter width: the remaining counter is CNT_W bits and never wraps, because the exit condition is remaining==1.
- Other inputs: in_valid while busy is ignored; there is no queueing.
- Illegal states: any unreachable state encoding returns to IDLE on the next edge.

Test Plan:
- Reset: assert RST asynchronously between clock edges. S=00, D=0, OE=1, in_ready=1, busy=0 immediately, before the next clock edge.
- Load-only job: in_data=1010, in_count=0, in_dir=0.
  - Sequence: one LOAD cycle with S=11 and D=1010, then two HOLD cycles with S=00, then done=1 for one cycle.
  - Downstream Q=1010 after the load. busy is high for exactly 4 cycles.
- Right shift: data 1010, dir=0, count=1. S sequence is 11, 01, 00, 00 followed by done. Downstream Q=0101 or x101 (register-defined fill); S=01 asserted for exactly 1 cycle.
- Left shift with count above WIDTH: data 1110, dir=1, count=5. S=10 for exactly 5 consecutive cycles. Total busy is 9 cycles. in_valid held high with new data throughout does not disturb the running job.
- Back-to-back jobs: hold in_valid continuously. The second acceptance occurs on the edge after DONE→IDLE, with exactly one in_ready=1 cycle between the two busy windows.
- Reset during SHIFT: RST asserted on the 3rd shift cycle of a count=7 job. No done pulse; S=00, OE=1 immediately. After release, a new job runs to completion normally.
